mux_4x1_stream: RTL and testbench

MUX_4X1_STREAM -- requirements
Module: mux_4x1_stream

---
 rtl/mux_4x1_stream.sv | 128 ++++++++++++
 tb/tb_mux_4x1_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_4x1_stream.sv
// mux_4x1_stream: 4-to-1 streaming multiplexer with a single output register.
//   Each of four valid/ready input channels competes for one output beat
//   register. Arbitration is round-robin by default, or fixed priority
//   (channel 0 highest) when the macro MUX_4X1_FIXED_PRIO_EN is defined.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in_valid/in_ready  per-channel handshake (4 bits, one-hot or zero ready)
//   din0..din3         channel data, DATA_W bits each
//   out_valid/out_ready, dout   downstream handshake and beat data
//   s1, s0             source channel of the held beat, {s1,s0}
//   beat_cnt           16-bit wrapping count of beats delivered downstream
module mux_4x1_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              s1,
  output logic              s0,
  output logic [15:0]       beat_cnt
);

  logic [3:0][DATA_W-1:0] din_a;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic [1:0]             src_q, src_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]             gnt_idx;
  logic                   gnt_any;
  logic                   load_ok;
  logic                   take;
  logic                   drain;

  assign din_a = {din3, din2, din1, din0};

`ifdef MUX_4X1_FIXED_PRIO_EN
  // Fixed priority: scan from the lowest priority upward so the last hit,
  // the lowest-numbered requester, wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(k);
      end
    end
  end
`else
  logic [1:0] p_q, p_d;

  // Round-robin: search P, P+1, P+2, P+3 (2-bit wrap). Scanning the offsets
  // in reverse leaves the nearest requester to P as the final winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[p_q + 2'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = p_q + 2'(k);
      end
    end
  end

  always_comb begin
    p_d = p_q;
    if (take) p_d = gnt_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= 2'd0;
    else        p_q <= p_d;
  end
`endif

  assign load_ok = !out_valid_q || out_ready;
  assign drain   = out_valid_q && out_ready;
  assign take    = gnt_any && load_ok;

  // Gated by rst_n so no channel sees a grant while reset is asserted.
  assign in_ready = (rst_n && take) ? (4'b0001 << gnt_idx) : 4'b0000;

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    src_d       = src_q;
    beat_cnt_d  = beat_cnt_q;
    if (drain) begin
      out_valid_d = 1'b0;
      beat_cnt_d  = beat_cnt_q + 16'd1;
    end
    // A load in the same cycle as a drain overrides the clear above.
    if (take) begin
      out_valid_d = 1'b1;
      dout_d      = din_a[gnt_idx];
      src_d       = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      src_q       <= 2'd0;
      beat_cnt_q  <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      src_q       <= src_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign s1        = src_q[1];
  assign s0        = src_q[0];
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mux_4x1_stream.sv
module tb_mux_4x1_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = 4'b0;
  logic [3:0]  in_ready;
  logic [7:0]  din0 = 8'h10, din1 = 8'h11, din2 = 8'h12, din3 = 8'h13;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  dout;
  logic        s1, s0;
  logic [15:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  mux_4x1_stream #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .s1(s1), .s0(s0), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_src;
    logic [7:0]  exp_dout;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset: assert, check forced values mid-reset, release away from edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready", {28'b0, in_ready}, 0);
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: round-robin pointer walk, stalls, idle drain, skip-ahead search.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd4};
    tbl[5]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd5};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd6};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd6};
    tbl[8]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd6};
    tbl[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11, 16'd6};
    tbl[10] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd7};
    tbl[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd8};
    tbl[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd9};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd10};

    // Reset with all channels requesting: nothing granted, outputs zero.
    in_valid = 4'b1111;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check("rst_ir_busy", {28'b0, in_ready}, 0);
    check("rst_dout", {24'b0, dout}, 0);
    check("rst_src", {30'b0, s1, s0}, 0);
    check("rst_cnt", {16'b0, beat_cnt}, 0);
    in_valid = 4'b0000;
    do_reset();

    // Single beat from channel 2.
    in_valid = 4'b0100;
    din2 = 8'hA5;
    out_ready = 1'b1;
    edge_step();
    in_valid = 4'b0000;
    check("c2_ov", {31'b0, out_valid}, 1);
    check("c2_dout", {24'b0, dout}, 32'hA5);
    check("c2_src", {30'b0, s1, s0}, 2);
    check("c2_cnt0", {16'b0, beat_cnt}, 0);
    edge_step();
    check("c2_cnt1", {16'b0, beat_cnt}, 1);
    check("c2_ov_clr", {31'b0, out_valid}, 0);
    din2 = 8'h12;

`ifdef MUX_4X1_FIXED_PRIO_EN
    // Fixed priority: channel 0 wins every cycle.
    do_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("fp_ir", {28'b0, in_ready}, 32'b0001);
      edge_step();
      check("fp_src", {30'b0, s1, s0}, 0);
      check("fp_dout", {24'b0, dout}, 32'h10);
    end
`else
    do_reset();
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_ir", i), {28'b0, in_ready}, {28'b0, tbl[i].exp_ir});
      edge_step();
      check($sformatf("v%0d_ov", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_ov});
      check($sformatf("v%0d_cnt", i), {16'b0, beat_cnt}, {16'b0, tbl[i].exp_cnt});
      if (tbl[i].exp_ov) begin
        check($sformatf("v%0d_src", i), {30'b0, s1, s0}, {30'b0, tbl[i].exp_src});
        check($sformatf("v%0d_dout", i), {24'b0, dout}, {24'b0, tbl[i].exp_dout});
      end
    end
`endif

    // Backpressure: channel 1 beat 3C held for 5 stalled cycles.
    do_reset();
    din1 = 8'h3C;
    in_valid = 4'b0010;
    out_ready = 1'b0;
    edge_step();
    din1 = 8'h11;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ir", {28'b0, in_ready}, 0);
      edge_step();
      check("bp_dout", {24'b0, dout}, 32'h3C);
      check("bp_src", {30'b0, s1, s0}, 1);
      check("bp_ov", {31'b0, out_valid}, 1);
    end
    out_ready = 1'b1;
    #1;
`ifdef MUX_4X1_FIXED_PRIO_EN
    check("bp_rel_ir", {28'b0, in_ready}, 32'b0001);
    edge_step();
    check("bp_rel_src", {30'b0, s1, s0}, 0);
    check("bp_rel_dout", {24'b0, dout}, 32'h10);
`else
    check("bp_rel_ir", {28'b0, in_ready}, 32'b0100);
    edge_step();
    check("bp_rel_src", {30'b0, s1, s0}, 2);
    check("bp_rel_dout", {24'b0, dout}, 32'h12);
`endif
    check("bp_rel_ov", {31'b0, out_valid}, 1);
    check("bp_rel_cnt", {16'b0, beat_cnt}, 1);

    // Mid-cycle reset pulse discards a held beat and restarts the pointer.
    do_reset();
    in_valid = 4'b0010;
    out_ready = 1'b0;
    edge_step();
    in_valid = 4'b0000;
    check("rp_pre_ov", {31'b0, out_valid}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rp_ov_now", {31'b0, out_valid}, 0);
    check("rp_cnt_now", {16'b0, beat_cnt}, 0);
    #2;
    rst_n = 1'b1;
    in_valid = 4'b1010;
    out_ready = 1'b1;
    #1;
    check("rp_ir", {28'b0, in_ready}, 32'b0010);
    edge_step();
    check("rp_src", {30'b0, s1, s0}, 1);
    check("rp_cnt", {16'b0, beat_cnt}, 0);

    // Counter wrap: steady stream, one beat delivered per edge after the first.
    do_reset();
    in_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    check("wrap_ffff", {16'b0, beat_cnt}, 32'hFFFF);
    edge_step();
    check("wrap_zero", {16'b0, beat_cnt}, 0);
    in_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
